// File: rtl/ahb_slave_responder_if.sv
// AHB slave-side bus bundle: address/data phase inputs and the slave response.
interface ahb_slave_responder_if;
   logic        HSELx;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [31:0] HWDATA;
   logic        HREADYin;
   logic        HREADYout;
   logic [1:0]  HRESP;
   logic [31:0] HRDATA;

   modport master (
      output HSELx, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADYin,
      input  HREADYout, HRESP, HRDATA
   );

   modport slave (
      input  HSELx, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADYin,
      output HREADYout, HRESP, HRDATA
   );
endinterface

// File: rtl/ahb_slave_responder.sv
// AHB slave responder: word-addressed register bank behind a pipelined AHB data phase
// with a fixed number of wait states and a two-cycle ERROR response.
module ahb_slave_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h8400_0000,
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned WAIT_STATES = 1
) (
   input logic                  HCLK,
   input logic                  HRESET,
   ahb_slave_responder_if.slave bus
);
   localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0] WinBytes = 32'(4 * DEPTH);
   // Only used when WAIT_STATES > 0; the wrap for zero is never loaded.
   localparam logic [3:0]  WaitLoad = 4'(WAIT_STATES - 1);

   typedef enum logic [2:0] {StIdle, StWait, StDone, StErr1, StErr2} state_e;

   state_e          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [IdxW-1:0] idx_q;
   logic [1:0]      lane_q;
   logic [2:0]      size_q;
   logic            write_q;
   logic [31:0]     bank_q [DEPTH];

   logic            accept;
   logic            can_start;
   logic            misalign;
   logic            req_err;
   logic [31:0]     offset;
   logic [3:0]      lane_en;
   logic            unused_htrans0;

   // BUSY vs IDLE makes no difference to the response.
   assign unused_htrans0 = bus.HTRANS[0];

   assign accept    = bus.HSELx & bus.HREADYin & bus.HTRANS[1];
   assign can_start = state_q inside {StIdle, StDone, StErr2};
   // Addresses below the base wrap to huge offsets, so one compare covers both ends.
   assign offset    = bus.HADDR - BASE_ADDR;

   // Alignment check for the requested transfer size.
   always_comb begin
      misalign = 1'b0;
      case (bus.HSIZE)
         3'b001:  misalign = bus.HADDR[0];
         3'b010:  misalign = (bus.HADDR[1:0] != 2'b00);
         default: misalign = 1'b0;
      endcase
   end

   assign req_err = (bus.HSIZE > 3'd2) | (offset >= WinBytes) | misalign;

   // Next-state logic for the data-phase sequencer.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StWait: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = StDone;
            end
         end
         StErr1: state_d = StErr2;
         default: begin
            state_d = StIdle;
            if (accept) begin
               if (req_err) begin
                  state_d = StErr1;
               end else if (WAIT_STATES == 0) begin
                  state_d = StDone;
               end else begin
                  state_d = StWait;
                  cnt_d   = WaitLoad;
               end
            end
         end
      endcase
   end

   // State, counter and data-phase context registers.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         idx_q   <= '0;
         lane_q  <= 2'b00;
         size_q  <= 3'b000;
         write_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept && can_start) begin
            idx_q   <= offset[IdxW+1:2];
            lane_q  <= bus.HADDR[1:0];
            size_q  <= bus.HSIZE;
            write_q <= bus.HWRITE;
         end
      end
   end

   // Little-endian byte lanes touched by the registered transfer.
   always_comb begin
      lane_en = 4'b0000;
      case (size_q)
         3'b000:  lane_en = 4'b0001 << lane_q;
         3'b001:  lane_en = lane_q[1] ? 4'b1100 : 4'b0011;
         default: lane_en = 4'b1111;
      endcase
   end

   // Register bank; writes commit at the edge ending the DONE cycle.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            bank_q[i] <= '0;
         end
      end else if (state_q == StDone && write_q) begin
         for (int b = 0; b < 4; b++) begin
            if (lane_en[b]) begin
               bank_q[idx_q][8*b +: 8] <= bus.HWDATA[8*b +: 8];
            end
         end
      end
   end

   assign bus.HREADYout = !(state_q inside {StWait, StErr1});
   assign bus.HRESP     = (state_q inside {StErr1, StErr2}) ? 2'b01 : 2'b00;
   assign bus.HRDATA    = (state_q == StDone && !write_q) ? bank_q[idx_q] : 32'h0;

endmodule

// File: tb/tb_ahb_slave_responder.sv
// Bench: two responders (zero and one wait state) share one AHB address/data bus with a
// per-slave select; a driver issues transfers and queues expected responses from a
// reference model, and a per-slave monitor checks every cycle against the queue head.
module tb_ahb_slave_responder;
   localparam logic [31:0] Base  = 32'h8400_0000;
   localparam int          Depth = 16;
   localparam int          Ws0   = 0;
   localparam int          Ws1   = 1;

   typedef struct {
      bit          err;
      bit          rd;
      logic [31:0] rdata;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  sel;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [31:0] haddr;
   logic [31:0] hwdata;
   logic        hready;

   exp_t        q [2][$];
   int          cyc [2];
   logic [31:0] mem [2][Depth];
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   ahb_slave_responder_if bus0 ();
   ahb_slave_responder_if bus1 ();

   assign hready = bus0.HREADYout & bus1.HREADYout;

   assign bus0.HSELx    = sel[0];
   assign bus0.HADDR    = haddr;
   assign bus0.HTRANS   = htrans;
   assign bus0.HWRITE   = hwrite;
   assign bus0.HSIZE    = hsize;
   assign bus0.HWDATA   = hwdata;
   assign bus0.HREADYin = hready;
   assign bus1.HSELx    = sel[1];
   assign bus1.HADDR    = haddr;
   assign bus1.HTRANS   = htrans;
   assign bus1.HWRITE   = hwrite;
   assign bus1.HSIZE    = hsize;
   assign bus1.HWDATA   = hwdata;
   assign bus1.HREADYin = hready;

   ahb_slave_responder #(.BASE_ADDR(Base), .DEPTH(Depth), .WAIT_STATES(Ws0)) dut0 (
      .HCLK   (clk),
      .HRESET (rst),
      .bus    (bus0.slave)
   );

   ahb_slave_responder #(.BASE_ADDR(Base), .DEPTH(Depth), .WAIT_STATES(Ws1)) dut1 (
      .HCLK   (clk),
      .HRESET (rst),
      .bus    (bus1.slave)
   );

   task automatic check(input string name, input int k, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s dut%0d @%0t: got %h expected %h", name, k, $time, act, exp);
      end
   endtask

   // Reference model: applies the transfer to the bank image and returns the response.
   function automatic exp_t model(input int k, input bit wr, input logic [2:0] sz,
                                  input logic [31:0] a, input logic [31:0] wd);
      exp_t        e;
      logic [31:0] off;
      int          nbytes;
      int          first;
      int          idx;
      off   = a - Base;
      first = int'(a[1:0]);
      e.rd    = !wr;
      e.rdata = 32'h0;
      if (sz > 3'd2) begin
         e.err = 1'b1;
      end else begin
         nbytes = 1 << sz;
         e.err  = (off >= 32'(4 * Depth)) || ((first % nbytes) != 0);
      end
      if (!e.err) begin
         idx = int'(off / 4);
         if (wr) begin
            for (int b = 0; b < 4; b++) begin
               if (b >= first && b < first + nbytes) begin
                  mem[k][idx][8*b +: 8] = wd[8*b +: 8];
               end
            end
         end else begin
            e.rdata = mem[k][idx];
         end
      end
      return e;
   endfunction

   // One bus transfer; tgt 2 selects neither slave.
   task automatic xfer(input int tgt, input logic [1:0] tr, input bit wr, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
      int n = 0;
      sel    = (tgt == 0) ? 2'b01 : (tgt == 1) ? 2'b10 : 2'b00;
      htrans = tr;
      hwrite = wr;
      hsize  = sz;
      haddr  = a;
      @(negedge clk);
      while (!hready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!hready) begin
         n_bad++;
         $display("FAIL hready_timeout @%0t: got 0 expected 1 within 50 cycles", $time);
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (sel[k] && tr[1] && hready) q[k].push_back(model(k, wr, sz, a, wd));
      end
      #1;
      hwdata = wd;
      sel    = 2'b00;
      htrans = 2'b00;
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      sel    = 2'b00;
      htrans = 2'b00;
      for (int k = 0; k < 2; k++) begin
         q[k].delete();
         for (int i = 0; i < Depth; i++) mem[k][i] = 32'h0;
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Per-cycle check of one slave against its queue head.
   task automatic mon(input int k, input int ws, input logic rdy, input logic [1:0] resp,
                      input logic [31:0] rd);
      exp_t        e;
      bit          last;
      logic        erdy;
      logic [1:0]  eresp;
      logic [31:0] ed;
      if (rst) begin
         cyc[k] = 0;
         return;
      end
      last = 1'b0;
      if (q[k].size() == 0) begin
         erdy  = 1'b1;
         eresp = 2'b00;
         ed    = 32'h0;
      end else begin
         e = q[k][0];
         if (e.err) begin
            last  = (cyc[k] == 1);
            erdy  = last;
            eresp = 2'b01;
            ed    = 32'h0;
         end else begin
            last  = (cyc[k] == ws);
            erdy  = last;
            eresp = 2'b00;
            ed    = (last && e.rd) ? e.rdata : 32'h0;
         end
      end
      check("hreadyout", k, 32'(rdy), 32'(erdy));
      check("hresp", k, 32'(resp), 32'(eresp));
      check("hrdata", k, rd, ed);
      if (q[k].size() != 0) begin
         if (last) begin
            void'(q[k].pop_front());
            cyc[k] = 0;
         end else begin
            cyc[k]++;
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0, Ws0, bus0.HREADYout, bus0.HRESP, bus0.HRDATA);
      mon(1, Ws1, bus1.HREADYout, bus1.HRESP, bus1.HRDATA);
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog @%0t: got no finish expected finish", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] a;
      logic [2:0]  sz;
      logic [1:0]  tr;
      int          tgt;
      hwdata = 32'h0;
      hwrite = 1'b0;
      hsize  = 3'b010;
      haddr  = Base;
      cyc[0] = 0;
      cyc[1] = 0;
      do_reset();

      // Reset contents, word write/read, byte lane merge.
      for (int k = 0; k < 2; k++) begin
         xfer(k, 2'b10, 1'b0, 3'b010, Base, 32'h0);
         xfer(k, 2'b10, 1'b1, 3'b010, Base + 4, 32'hDEAD_BEEF);
         xfer(k, 2'b10, 1'b0, 3'b010, Base + 4, 32'h0);
         xfer(k, 2'b10, 1'b1, 3'b010, Base + 4, 32'h1122_3344);
         xfer(k, 2'b10, 1'b1, 3'b000, Base + 6, 32'h00AB_0000);
         xfer(k, 2'b10, 1'b0, 3'b010, Base + 4, 32'h0);
         // Errors: out of range, misaligned word, illegal size; bank must stay intact.
         xfer(k, 2'b10, 1'b1, 3'b010, Base + 32'h40, 32'hFFFF_FFFF);
         xfer(k, 2'b11, 1'b1, 3'b010, Base + 2, 32'hFFFF_FFFF);
         xfer(k, 2'b10, 1'b1, 3'b011, Base + 4, 32'hFFFF_FFFF);
         xfer(k, 2'b00, 1'b1, 3'b010, Base + 4, 32'hFFFF_FFFF);
         xfer(k, 2'b01, 1'b1, 3'b010, Base + 4, 32'hFFFF_FFFF);
         xfer(k, 2'b10, 1'b0, 3'b010, Base + 4, 32'h0);
         xfer(k, 2'b10, 1'b1, 3'b010, Base + 8, 32'hCAFE_0001);
         xfer(k, 2'b10, 1'b0, 3'b010, Base + 8, 32'h0);
      end

      // Reset during the wait state of a write.
      xfer(1, 2'b10, 1'b1, 3'b010, Base + 12, 32'h55AA_55AA);
      do_reset();
      xfer(1, 2'b10, 1'b0, 3'b010, Base + 12, 32'h0);
      xfer(0, 2'b10, 1'b0, 3'b010, Base + 8, 32'h0);

      // Randomized traffic across both slaves and idle cycles.
      for (int i = 0; i < 400; i++) begin
         tgt = int'($urandom_range(0, 2));
         tr  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
         sz  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
         a   = Base + 32'($urandom_range(0, 4 * Depth + 7));
         if ($urandom_range(0, 19) == 0) a = $urandom;
         if (sz <= 3'd2 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
         xfer(tgt, tr, 1'($urandom_range(0, 1)), sz, a, $urandom);
      end

      repeat (4) xfer(2, 2'b00, 1'b0, 3'b010, Base, 32'h0);
      check("drain", 0, 32'(q[0].size()), 32'd0);
      check("drain", 1, 32'(q[1].size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
